// File: rtl/kyber_hpm1pe.sv
// Single-PE Kyber coefficient store (A, B) with streaming load/read and
// degree-1 basemul (PWM2) over q = 3329; start_fntt/start_intt are reserved.
module kyber_hpm1pe (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_a_f,
    input  logic        load_a_i,
    input  logic        load_b_f,
    input  logic        load_b_i,
    input  logic        read_a,
    input  logic        read_b,
    input  logic        start_ab,
    input  logic        start_fntt,
    input  logic        start_intt,
    input  logic        start_pwm2,
    input  logic [11:0] din,
    output logic [11:0] dout,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READ,
        S_PWM,
        S_DONE
    } state_t;

    // Barrett reduction for x < 2^26 with m = floor(2^26 / 3329); one correction step suffices.
    function automatic logic [11:0] f_mod(input logic [25:0] x);
        logic [41:0] w_prod;
        logic [15:0] w_qh;
        logic [12:0] w_r;
        w_prod = {16'd0, x} * 42'd20158;
        w_qh   = 16'(w_prod >> 26);
        w_r    = 13'(x - ({10'd0, w_qh} * 26'd3329));
        if (w_r >= 13'd3329) w_r = w_r - 13'd3329;
        return 12'(w_r);
    endfunction

    function automatic logic [7:0] f_brv8(input logic [7:0] x);
        logic [7:0] w_r;
        for (int b = 0; b < 8; b++) w_r[b] = x[7-b];
        return w_r;
    endfunction

    // g_i = 17^(2*brv7(i)+1) mod q, evaluated at elaboration by square-and-multiply.
    function automatic logic [11:0] f_zeta(input int idx);
        int e;
        int p;
        int base;
        e = 0;
        for (int b = 0; b < 7; b++) e = e | (((idx >> b) & 1) << (6 - b));
        e    = 2 * e + 1;
        p    = 1;
        base = 17;
        for (int k = 0; k < 8; k++) begin
            if (((e >> k) & 1) == 1) p = (p * base) % 3329;
            base = (base * base) % 3329;
        end
        return 12'(p);
    endfunction

    logic [11:0] w_zeta_rom [128];
    for (genvar gi = 0; gi < 128; gi++) begin : g_zeta
        localparam logic [11:0] LP_G = f_zeta(gi);
        assign w_zeta_rom[gi] = LP_G;
    end

    logic w_unused_reserved;
    assign w_unused_reserved = start_fntt | start_intt;

    state_t      r_state;
    state_t      w_next_state;
    logic [8:0]  r_cnt;
    logic        r_poly_b;
    logic        r_rev;
    logic        r_dst_b;
    logic        w_cmd_poly_b;
    logic        w_cmd_rev;
    logic        w_done;

    // Priority-resolved command decode; pulses are only honoured in IDLE.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_next_state = r_state;
        w_cmd_poly_b = 1'b0;
        w_cmd_rev    = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (load_a_i) begin
                    w_next_state = S_LOAD;
                end else if (load_a_f) begin
                    w_next_state = S_LOAD;
                    w_cmd_rev    = 1'b1;
                end else if (load_b_i) begin
                    w_next_state = S_LOAD;
                    w_cmd_poly_b = 1'b1;
                end else if (load_b_f) begin
                    w_next_state = S_LOAD;
                    w_cmd_poly_b = 1'b1;
                    w_cmd_rev    = 1'b1;
                end else if (start_pwm2) begin
                    w_next_state = S_PWM;
                end else if (read_a) begin
                    w_next_state = S_READ;
                end else if (read_b) begin
                    w_next_state = S_READ;
                    w_cmd_poly_b = 1'b1;
                end
            end
            S_LOAD, S_READ: begin
                if (r_cnt[7:0] == 8'hFF) w_next_state = S_IDLE;
            end
            S_PWM: begin
                if (r_cnt == 9'h1FF) w_next_state = S_DONE;
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign done = w_done;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 9'd0;
            r_poly_b <= 1'b0;
            r_rev    <= 1'b0;
            r_dst_b  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE) begin
                r_poly_b <= w_cmd_poly_b;
                r_rev    <= w_cmd_rev;
                r_dst_b  <= start_ab;
            end
            if ((w_next_state == r_state) &&
                (r_state == S_LOAD || r_state == S_READ || r_state == S_PWM))
                r_cnt <= r_cnt + 9'd1;
            else
                r_cnt <= 9'd0;
        end
    end

    // Stream word j carries coefficient 4k + {0,2,1,3}[j mod 4]; bank = idx[1], row = {idx[7:2], idx[0]}.
    logic [7:0] w_word;
    logic [7:0] w_nat_idx;
    logic [7:0] w_load_idx;
    logic       w_load_bank;
    logic [6:0] w_load_row;
    logic       w_read_bank;
    logic [6:0] w_read_row;

    assign w_word      = r_cnt[7:0];
    assign w_nat_idx   = {w_word[7:2], w_word[0], w_word[1]};
    assign w_load_idx  = r_rev ? f_brv8(w_nat_idx) : w_nat_idx;
    assign w_load_bank = w_load_idx[1];
    assign w_load_row  = {w_load_idx[7:2], w_load_idx[0]};
    assign w_read_bank = w_nat_idx[1];
    assign w_read_row  = {w_nat_idx[7:2], w_nat_idx[0]};

    // PWM walks pair i over four phases: read even row, read odd row, write c[2i], write c[2i+1].
    logic [6:0]  w_pair;
    logic [1:0]  w_phase;
    logic        w_pbank;
    logic [11:0] w_zeta;

    assign w_pair  = r_cnt[8:2];
    assign w_phase = r_cnt[1:0];
    assign w_pbank = w_pair[0];
    assign w_zeta  = w_zeta_rom[w_pair];

    logic [11:0] r_a_br1 [128];
    logic [11:0] r_a_br2 [128];
    logic [11:0] r_b_br1 [128];
    logic [11:0] r_b_br2 [128];
    logic [11:0] r_q_a1;
    logic [11:0] r_q_a2;
    logic [11:0] r_q_b1;
    logic [11:0] r_q_b2;

    logic [11:0] r_a_even;
    logic [11:0] r_b_even;
    logic [11:0] r_c1;
    logic [11:0] w_q_a;
    logic [11:0] w_q_b;
    logic [23:0] w_p00;
    logic [23:0] w_p11;
    logic [23:0] w_p01;
    logic [23:0] w_p10;
    logic [11:0] w_r11;
    logic [23:0] w_p11g;
    logic [11:0] w_c0;
    logic [11:0] w_c1;

    assign w_q_a  = w_pbank ? r_q_a2 : r_q_a1;
    assign w_q_b  = w_pbank ? r_q_b2 : r_q_b1;
    assign w_p00  = {12'd0, r_a_even} * {12'd0, r_b_even};
    assign w_p11  = {12'd0, w_q_a} * {12'd0, w_q_b};
    assign w_p01  = {12'd0, r_a_even} * {12'd0, w_q_b};
    assign w_p10  = {12'd0, w_q_a} * {12'd0, r_b_even};
    assign w_r11  = f_mod({2'd0, w_p11});
    assign w_p11g = {12'd0, w_r11} * {12'd0, w_zeta};
    assign w_c0   = f_mod({2'd0, w_p00} + {2'd0, w_p11g});
    assign w_c1   = f_mod({2'd0, w_p01} + {2'd0, w_p10});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_even <= 12'd0;
            r_b_even <= 12'd0;
            r_c1     <= 12'd0;
        end else if (r_state == S_PWM) begin
            if (w_phase == 2'd1) begin
                r_a_even <= w_q_a;
                r_b_even <= w_q_b;
            end
            if (w_phase == 2'd2) r_c1 <= w_c1;
        end
    end

    logic        w_we_a1;
    logic        w_we_a2;
    logic        w_we_b1;
    logic        w_we_b2;
    logic [6:0]  w_waddr;
    logic [11:0] w_wdata;
    logic [6:0]  w_raddr;
    logic        w_wr_poly_b;
    logic        w_wr_bank;
    logic        w_wr_en;

    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_poly_b = 1'b0;
        w_wr_bank   = 1'b0;
        w_waddr     = 7'd0;
        w_wdata     = 12'd0;
        w_raddr     = 7'd0;
        case (r_state)
            S_LOAD: begin
                w_wr_en     = 1'b1;
                w_wr_poly_b = r_poly_b;
                w_wr_bank   = w_load_bank;
                w_waddr     = w_load_row;
                w_wdata     = din;
            end
            S_READ: w_raddr = w_read_row;
            S_PWM: begin
                w_raddr     = {w_pair[6:1], w_phase[0]};
                w_wr_poly_b = r_dst_b;
                w_wr_bank   = w_pbank;
                w_waddr     = {w_pair[6:1], w_phase[0]};
                if (w_phase == 2'd2) begin
                    w_wr_en = 1'b1;
                    w_wdata = w_c0;
                end else if (w_phase == 2'd3) begin
                    w_wr_en = 1'b1;
                    w_wdata = r_c1;
                end
            end
            default: ;
        endcase
    end

    assign w_we_a1 = w_wr_en & ~w_wr_poly_b & ~w_wr_bank;
    assign w_we_a2 = w_wr_en & ~w_wr_poly_b &  w_wr_bank;
    assign w_we_b1 = w_wr_en &  w_wr_poly_b & ~w_wr_bank;
    assign w_we_b2 = w_wr_en &  w_wr_poly_b &  w_wr_bank;

    always_ff @(posedge clk) begin
        // NOTE: memory banks and their read registers have no reset; contents persist across reset.
        if (w_we_a1) r_a_br1[w_waddr] <= w_wdata;
        if (w_we_a2) r_a_br2[w_waddr] <= w_wdata;
        if (w_we_b1) r_b_br1[w_waddr] <= w_wdata;
        if (w_we_b2) r_b_br2[w_waddr] <= w_wdata;
        r_q_a1 <= r_a_br1[w_raddr];
        r_q_a2 <= r_a_br2[w_raddr];
        r_q_b1 <= r_b_br1[w_raddr];
        r_q_b2 <= r_b_br2[w_raddr];
    end

    // Read path: bank read register, then output register, giving word j on cycle t+3+j.
    logic        r_rd_v;
    logic        r_rd_bank;
    logic        r_rd_poly;
    logic [11:0] r_dout;
    logic [11:0] w_rd_word;

    assign w_rd_word = r_rd_poly ? (r_rd_bank ? r_q_b2 : r_q_b1)
                                 : (r_rd_bank ? r_q_a2 : r_q_a1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_v    <= 1'b0;
            r_rd_bank <= 1'b0;
            r_rd_poly <= 1'b0;
            r_dout    <= 12'd0;
        end else begin
            r_rd_v    <= (r_state == S_READ);
            r_rd_bank <= w_read_bank;
            r_rd_poly <= r_poly_b;
            r_dout    <= r_rd_v ? w_rd_word : 12'd0;
        end
    end

    assign dout = r_dout;

endmodule

// File: tb/tb_kyber_hpm1pe.sv
// Self-checking bench for kyber_hpm1pe: directed sequence with random operands
// checked against a coefficient-level model of load, read and Kyber basemul.
module tb_kyber_hpm1pe;

    localparam int Q = 3329;

    logic        clk;
    logic        reset;
    logic        load_a_f, load_a_i, load_b_f, load_b_i;
    logic        read_a, read_b, start_ab, start_fntt, start_intt, start_pwm2;
    logic [11:0] din;
    logic [11:0] dout;
    logic        done;

    int checks = 0;
    int errors = 0;
    int ma [256];
    int mb [256];
    int stim [256];

    kyber_hpm1pe dut (
        .clk(clk), .reset(reset),
        .load_a_f(load_a_f), .load_a_i(load_a_i),
        .load_b_f(load_b_f), .load_b_i(load_b_i),
        .read_a(read_a), .read_b(read_b),
        .start_ab(start_ab), .start_fntt(start_fntt), .start_intt(start_intt),
        .start_pwm2(start_pwm2), .din(din), .dout(dout), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int brv(input int v, input int bits);
        int r = 0;
        for (int b = 0; b < bits; b++) if (((v >> b) & 1) == 1) r |= 1 << (bits - 1 - b);
        return r;
    endfunction

    // Coefficient index carried by stream word j: c0, c2, c1, c3, c4, c6, ...
    function automatic int stream_idx(input int j);
        int m = j % 4;
        return (j / 4) * 4 + ((m == 1) ? 2 : (m == 2) ? 1 : m);
    endfunction

    function automatic int gamma(input int i);
        longint p = 1;
        int e = 2 * brv(i, 7) + 1;
        for (int k = 0; k < e; k++) p = (p * 17) % Q;
        return int'(p);
    endfunction

    task automatic model_pwm(input bit to_b);
        longint a0, a1, b0, b1, c0, c1;
        for (int i = 0; i < 128; i++) begin
            a0 = ma[2*i]; a1 = ma[2*i+1]; b0 = mb[2*i]; b1 = mb[2*i+1];
            c0 = (a0 * b0 + ((a1 * b1) % Q) * gamma(i)) % Q;
            c1 = (a0 * b1 + a1 * b0) % Q;
            if (to_b) begin mb[2*i] = int'(c0); mb[2*i+1] = int'(c1); end
            else      begin ma[2*i] = int'(c0); ma[2*i+1] = int'(c1); end
        end
    endtask

    task automatic fill_random();
        for (int j = 0; j < 256; j++) stim[j] = int'($urandom_range(Q - 1, 0));
    endtask

    task automatic fill_const(input int v);
        for (int j = 0; j < 256; j++) stim[j] = v;
    endtask

    task automatic do_load(input bit is_b, input bit rev);
        int dst;
        load_a_i = !is_b && !rev;
        load_a_f = !is_b &&  rev;
        load_b_i =  is_b && !rev;
        load_b_f =  is_b &&  rev;
        tick();
        {load_a_i, load_a_f, load_b_i, load_b_f} = 4'b0;
        for (int j = 0; j < 256; j++) begin
            din = stim[j][11:0];
            dst = rev ? brv(stream_idx(j), 8) : stream_idx(j);
            if (is_b) mb[dst] = stim[j]; else ma[dst] = stim[j];
            tick();
        end
        din = 12'd0;
    endtask

    task automatic do_read(input bit is_b, input string tag);
        read_a = !is_b;
        read_b = is_b;
        tick();
        read_a = 1'b0;
        read_b = 1'b0;
        tick();
        check({tag, "_lead"}, dout, 0);
        tick();
        for (int j = 0; j < 256; j++) begin
            check($sformatf("%s[%0d]", tag, j), dout, is_b ? mb[stream_idx(j)] : ma[stream_idx(j)]);
            tick();
        end
        check({tag, "_tail"}, dout, 0);
    endtask

    task automatic do_pwm(input bit to_b);
        int n = 0;
        start_ab   = to_b;
        start_pwm2 = 1'b1;
        tick();
        start_pwm2 = 1'b0;
        start_ab   = 1'b0;
        while (done !== 1'b1 && n < 600) begin
            tick();
            n++;
        end
        check("pwm_done_seen", done, 1);
        model_pwm(to_b);
        tick();
        check("pwm_done_one_cycle", done, 0);
    endtask

    initial begin
        int dcnt;
        reset = 1'b1;
        {load_a_f, load_a_i, load_b_f, load_b_i} = 4'b0;
        {read_a, read_b, start_ab, start_fntt, start_intt, start_pwm2} = 6'b0;
        din = 12'd0;
        repeat (3) tick();
        check("reset_done", done, 0);
        check("reset_dout", dout, 0);
        reset = 1'b0;

        // Idle with reserved ports toggling: nothing may move.
        for (int c = 0; c < 100; c++) begin
            start_fntt = c[0];
            start_intt = c[1];
            tick();
            check("idle_outputs", {19'd0, done, dout}, 0);
        end
        start_fntt = 1'b0;
        start_intt = 1'b0;

        // a[i] = i in natural order; read stream must be 0, 2, 1, 3, ...
        for (int j = 0; j < 256; j++) stim[j] = stream_idx(j);
        do_load(1'b0, 1'b0);
        do_read(1'b0, "ramp_a");

        // All-ones operands: c[2i+1] = 2, c[2i] = 1 + g_i.
        fill_const(1);
        do_load(1'b0, 1'b0);
        do_load(1'b1, 1'b0);
        do_pwm(1'b0);
        do_read(1'b0, "ones_a");

        // Random A via bit-reversed load, random B natural; result to A, B untouched.
        fill_random();
        do_load(1'b0, 1'b1);
        fill_random();
        do_load(1'b1, 1'b0);
        do_pwm(1'b0);
        do_read(1'b0, "rnd_a");
        do_read(1'b1, "rnd_b_keep");

        // Random again with result to B, A untouched.
        fill_random();
        do_load(1'b0, 1'b0);
        fill_random();
        do_load(1'b1, 1'b1);
        do_pwm(1'b1);
        do_read(1'b1, "rnd_b");
        do_read(1'b0, "rnd_a_keep");

        // Maximum operands.
        fill_const(Q - 1);
        do_load(1'b0, 1'b1);
        do_load(1'b1, 1'b1);
        do_pwm(1'b0);
        do_read(1'b0, "max_a");

        // Load_b_i while PWM busy is ignored; reset mid-PWM aborts with no done.
        fill_random();
        do_load(1'b1, 1'b0);
        start_ab   = 1'b0;
        start_pwm2 = 1'b1;
        tick();
        start_pwm2 = 1'b0;
        repeat (20) tick();
        load_b_i = 1'b1;
        tick();
        load_b_i = 1'b0;
        dcnt = 0;
        for (int c = 0; c < 40; c++) begin
            din = 12'($urandom_range(Q - 1, 0));
            tick();
            if (done === 1'b1) dcnt++;
        end
        din   = 12'd0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 700; c++) begin
            tick();
            if (done !== 1'b0) dcnt++;
        end
        check("abort_no_done", dcnt, 0);
        check("abort_dout", dout, 0);
        fill_random();
        do_load(1'b0, 1'b0);
        do_read(1'b0, "after_abort_a");
        do_read(1'b1, "after_abort_b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
